// File: rtl/bht_ctrl.sv
// bht_ctrl: branch history table of 2-bit saturating counters with init sweep and branch statistics
module bht_ctrl #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_VAL   = 2'b01
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        predict_valid,
    output logic        predict,
    output logic        ready,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic        update_mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);
    localparam int N = 1 << INDEX_BITS;
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nxt;
    logic [INDEX_BITS-1:0] init_idx, init_idx_nxt, lidx, uidx;
    logic [1:0] tbl [N];
    logic [1:0] ucur, unew, lcur;
    logic upd_en, lk_en;
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0], update_pc[31:INDEX_BITS+2], update_pc[1:0]};
    assign lidx   = lookup_pc[INDEX_BITS+1:2];
    assign uidx   = update_pc[INDEX_BITS+1:2];
    assign ready  = (state == RUN);
    assign lk_en  = lookup_valid & ready;
    assign upd_en = update_valid & ready & ~clear;
    assign ucur   = tbl[uidx];
    assign unew   = update_taken ? (&ucur ? ucur : ucur + 2'd1) : (~|ucur ? ucur : ucur - 2'd1);
    // write-first: a same-index update this cycle is visible to the lookup
    assign lcur   = (upd_en && uidx == lidx) ? unew : tbl[lidx];
    always_comb begin
        state_nxt    = state;
        init_idx_nxt = init_idx;
        if (clear) begin
            state_nxt    = INIT;
            init_idx_nxt = '0;
        end else if (state == INIT) begin
            init_idx_nxt = init_idx + 1'b1;
            state_nxt    = &init_idx ? RUN : INIT;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= INIT;
            init_idx      <= '0;
            predict_valid <= 1'b0;
            predict       <= 1'b0;
            branch_cnt    <= '0;
            miss_cnt      <= '0;
        end else begin
            state         <= state_nxt;
            init_idx      <= init_idx_nxt;
            predict_valid <= lk_en;
            predict       <= lk_en & lcur[1];
            branch_cnt    <= branch_cnt + 32'(ready & update_valid);
            miss_cnt      <= miss_cnt + 32'(ready & update_valid & update_mispredict);
        end
    end
    // table has no reset; the sweep defines its contents
    always_ff @(posedge clk) begin
        if (state == INIT)
            tbl[init_idx] <= INIT_VAL;
        else if (upd_en)
            tbl[uidx] <= unew;
    end
endmodule

// File: tb/tb_bht_ctrl.sv
// tb_bht_ctrl: directed self-checking bench for bht_ctrl
module tb_bht_ctrl;
    logic        clk = 0, rstn = 0, clear = 0, lookup_valid = 0;
    logic        update_valid = 0, update_taken = 0, update_mispredict = 0;
    logic [31:0] lookup_pc = 0, update_pc = 0;
    logic        predict_valid, predict, ready;
    logic [31:0] branch_cnt, miss_cnt;
    int checks = 0, errors = 0;

    bht_ctrl dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .predict_valid(predict_valid), .predict(predict), .ready(ready),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_mispredict(update_mispredict),
        .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        lookup_valid = 1;
        lookup_pc    = pc;
        tick;
        lookup_valid = 0;
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic m);
        update_valid      = 1;
        update_pc         = pc;
        update_taken      = t;
        update_mispredict = m;
        tick;
        update_valid      = 0;
        update_mispredict = 0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 200) begin
            tick;
            n++;
        end
        chk(tag, n, 64);
    endtask

    initial begin
        int n;
        tick;
        tick;
        chk("rst_ready", ready, 0);
        chk("rst_pv", predict_valid, 0);
        chk("rst_pred", predict, 0);
        chk("rst_branch", branch_cnt, 0);
        chk("rst_miss", miss_cnt, 0);
        rstn = 1;
        wait_ready("init_sweep_len");

        lookup(32'h1C000000);
        chk("first_pv", predict_valid, 1);
        chk("first_pred", predict, 0);
        tick;
        chk("pv_drop", predict_valid, 0);
        chk("pred_drop", predict, 0);

        update(32'h1C000010, 1, 0);
        update(32'h1C000010, 1, 0);
        lookup(32'h1C000010);
        chk("train_11", predict, 1);
        repeat (3) update(32'h1C000010, 0, 0);
        lookup(32'h1C000010);
        chk("train_00", predict, 0);
        update(32'h1C000010, 0, 0);
        update(32'h1C000010, 1, 0);
        lookup(32'h1C000010);
        chk("sat_low", predict, 0);
        update(32'h1C000010, 1, 0);
        lookup(32'h1C000010);
        chk("back_to_10", predict, 1);
        update(32'h1C000010, 1, 0);
        chk("branch_9", branch_cnt, 9);

        lookup_valid = 1;
        lookup_pc    = 32'h1C000020;
        update(32'h1C000020, 1, 0);
        lookup_valid = 0;
        chk("fwd_pv", predict_valid, 1);
        chk("fwd_pred", predict, 1);
        lookup_valid = 1;
        lookup_pc    = 32'h1C000000;
        update(32'h1C000020, 1, 0);
        lookup_valid = 0;
        chk("indep_pred", predict, 0);
        lookup(32'h1C000010);
        chk("entry4_pre_clear", predict, 1);

        clear = 1;
        tick;
        clear = 0;
        chk("clear_drop", ready, 0);
        n = 0;
        while (!ready && n < 200) begin
            update_valid = 1; update_pc = 32'h1C000010; update_taken = 1; update_mispredict = 1;
            lookup_valid = 1; lookup_pc = 32'h1C000010;
            tick;
            n++;
        end
        update_valid = 0; update_mispredict = 0; lookup_valid = 0;
        chk("clear_sweep_len", n, 64);
        chk("sweep_lookup_pv", predict_valid, 0);
        chk("sweep_branch", branch_cnt, 11);
        chk("sweep_miss", miss_cnt, 0);
        lookup(32'h1C000010);
        chk("entry4_post_clear", predict, 0);

        rstn = 0;
        tick;
        chk("rst2_branch", branch_cnt, 0);
        rstn = 1;
        wait_ready("rst2_sweep_len");
        for (int i = 0; i < 10; i++)
            update(32'h10000000 + 32'(i << 2), i[0], i < 3);
        chk("stat_branch", branch_cnt, 10);
        chk("stat_miss", miss_cnt, 3);
        clear = 1;
        tick;
        clear = 0;
        wait_ready("clear2_sweep_len");
        chk("clear_keep_branch", branch_cnt, 10);
        chk("clear_keep_miss", miss_cnt, 3);

        clear = 1;
        tick;
        clear = 0;
        repeat (20) tick;
        rstn = 0;
        #1;
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_branch", branch_cnt, 0);
        chk("mid_rst_miss", miss_cnt, 0);
        tick;
        rstn = 1;
        wait_ready("mid_rst_sweep_len");

        update(32'h00000100, 1, 0);
        update(32'h00000100, 1, 0);
        lookup(32'h00010100);
        chk("alias_pred", predict, 1);
        lookup(32'h00000104);
        chk("neighbour_pred", predict, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
